// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its bus.
package fetch_pkg;

   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_out_t;

   function automatic logic [31:0] alignPc(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
interface fetch_if;
   import fetch_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;

   modport master (output ireq, input iresp);
   modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO: entry 0 is always the head, so the outputs come straight from a register.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  fetch_out_t din_i,
   output logic [1:0] count_o,
   output fetch_out_t head_o
);

   fetch_out_t e0_q, e1_q;
   logic [1:0] count_q;

   // Flush wins over push; a push together with a pop at count 2 is never requested.
   always_ff @(posedge clk) begin
      if (!resetn || flush_i) begin
         count_q <= 2'd0;
      end else begin
         unique case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) e0_q <= din_i;
               else                 e1_q <= din_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               e0_q    <= e1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  e0_q <= din_i;
               end else begin
                  e0_q <= e1_q;
                  e1_q <= din_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = e0_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: one outstanding ibus read at a time, results buffered for decode,
// wrong-path responses discarded after a redirect.
module fetch
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   fetch_if.master     ibus,
   input  logic        redir_valid_i,
   input  logic [31:0] redir_pc_i,
   output logic        out_valid_o,
   output logic [31:0] out_pc_o,
   output logic [31:0] out_instr_o,
   input  logic        out_ready_i
);

   fetch_state_t state_q;
   logic [31:0]  pc_q, pc_d, req_addr_q;
   logic         kill_q, kill_d;
   logic [1:0]   fifoCount, countAfter;
   logic         complete, push, pop, canIssue, inFlight, issue;
   fetch_out_t   head, pushData;

   // Only issue when the buffer is guaranteed a free slot for the response, since data_ok cannot stall.
   always_comb begin
      complete   = ((state_q == REQ) && ibus.iresp.addr_ok && ibus.iresp.data_ok) ||
                   ((state_q == WAIT) && ibus.iresp.data_ok);
      push       = complete && !kill_q && !redir_valid_i;
      pop        = out_valid_o && out_ready_i && !redir_valid_i;
      countAfter = fifoCount + {1'b0, push} - {1'b0, pop};
      canIssue   = (countAfter <= 2'd1);
      inFlight   = (state_q != IDLE) && !complete;
      issue      = ((state_q == IDLE) || complete) && !redir_valid_i && canIssue;

      pc_d = pc_q;
      if (redir_valid_i)          pc_d = alignPc(redir_pc_i);
      else if (complete && !kill_q) pc_d = req_addr_q + 32'd4;

      kill_d = kill_q;
      if (complete)                  kill_d = 1'b0;
      if (redir_valid_i && inFlight) kill_d = 1'b1;

      pushData.pc    = req_addr_q;
      pushData.instr = ibus.iresp.data;
   end

   // A redirect always parks the FSM in IDLE for a cycle unless a killed transaction is still open.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         kill_q     <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         kill_q <= kill_d;
         unique case (state_q)
            IDLE: begin
               if (issue) begin
                  state_q    <= REQ;
                  req_addr_q <= pc_d;
               end
            end
            REQ: begin
               if (complete) begin
                  if (issue) req_addr_q <= pc_d;
                  else       state_q    <= IDLE;
               end else if (ibus.iresp.addr_ok) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (complete) begin
                  if (issue) begin
                     state_q    <= REQ;
                     req_addr_q <= pc_d;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fetch_fifo u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redir_valid_i),
      .din_i   (pushData),
      .count_o (fifoCount),
      .head_o  (head)
   );

   assign ibus.ireq.valid = (state_q == REQ);
   assign ibus.ireq.addr  = req_addr_q;
   assign out_valid_o     = (fifoCount != 2'd0);
   assign out_pc_o        = head.pc;
   assign out_instr_o     = head.instr;

endmodule

// File: tb/tb_fetch.sv
// Randomized and directed bench for fetch: a latency-programmable memory model plus a
// program-order reference stream that every accepted instruction is checked against.
module tb_fetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirValid;
   logic [31:0] redirPc;
   logic        outReady;
   logic        outValid;
   logic [31:0] outPc;
   logic [31:0] outInstr;

   fetch_if bus ();

   fetch dut (
      .clk           (clk),
      .resetn        (resetn),
      .ibus          (bus),
      .redir_valid_i (redirValid),
      .redir_pc_i    (redirPc),
      .out_valid_o   (outValid),
      .out_pc_o      (outPc),
      .out_instr_o   (outInstr),
      .out_ready_i   (outReady)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          addrLat = 0, dataLat = 0;
   bit          randLat = 1'b0;
   bit          pend = 1'b0, outst = 1'b0;
   int          acnt = 0, dcnt = 0, curD = 0;
   logic [31:0] pendAddr = '0, outAddr = '0;
   int          reqStarts = 0;

   logic [31:0] expPc = RESET_PC;
   int          accepted = 0;
   bit          prevRedir = 1'b0;

   function automatic logic [31:0] instrFor(input logic [31:0] a);
      return 32'h2408_0001 + ((a - RESET_PC) * 32'h0001_0003);
   endfunction

   // Memory slave: decides this cycle's response just after the edge, honouring the programmed latencies.
   always @(posedge clk) begin
      #1;
      if (!resetn) begin
         pend      = 1'b0;
         outst     = 1'b0;
         bus.iresp = '0;
      end else begin
         if (bus.iresp.data_ok) outst = 1'b0;
         else if (bus.iresp.addr_ok) begin
            outst = 1'b1;
            dcnt  = curD - 1;
         end
         bus.iresp.addr_ok = 1'b0;
         bus.iresp.data_ok = 1'b0;
         if (outst) begin
            total++;
            if (bus.ireq.valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL one_outstanding: valid=%b want 0", bus.ireq.valid);
            end
            if (dcnt == 0) begin
               bus.iresp.data_ok = 1'b1;
               bus.iresp.data    = instrFor(outAddr);
            end else dcnt--;
         end else if (pend || bus.ireq.valid === 1'b1) begin
            if (!pend) begin
               pend     = 1'b1;
               pendAddr = bus.ireq.addr;
               reqStarts++;
               if (randLat) begin
                  addrLat = $urandom_range(0, 2);
                  dataLat = $urandom_range(0, 2);
               end
               acnt = addrLat;
               curD = dataLat;
               total++;
               if (bus.ireq.addr[1:0] !== 2'b00) begin
                  bad++;
                  $display("[TB] FAIL addr_align: addr=%h", bus.ireq.addr);
               end
            end else begin
               total++;
               if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== pendAddr) begin
                  bad++;
                  $display("[TB] FAIL req_stable: valid=%b addr=%h want 1 %h",
                           bus.ireq.valid, bus.ireq.addr, pendAddr);
               end
            end
            if (acnt == 0) begin
               bus.iresp.addr_ok = 1'b1;
               pend              = 1'b0;
               outAddr           = pendAddr;
               if (curD == 0) begin
                  bus.iresp.data_ok = 1'b1;
                  bus.iresp.data    = instrFor(pendAddr);
               end
            end else acnt--;
         end
      end
   end

   // Reference stream: decode must see consecutive words starting at the latest redirect target.
   always @(negedge clk) begin
      #2;
      if (prevRedir) begin
         total++;
         if (outValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_after_redirect: out_valid=%b want 0", outValid);
         end
      end
      if (!resetn) expPc = RESET_PC;
      else if (redirValid) expPc = redirPc & ~32'h3;
      else if (outValid === 1'b1 && outReady === 1'b1) begin
         total++;
         if (outPc !== expPc || outInstr !== instrFor(expPc)) begin
            bad++;
            $display("[TB] FAIL stream: pc=%h instr=%h want %h %h", outPc, outInstr, expPc, instrFor(expPc));
         end
         expPc = expPc + 32'd4;
         accepted++;
      end
      prevRedir = redirValid && resetn;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0; outReady = 1'b1; redirValid = 1'b0; redirPc = '0;
      randLat = 1'b0; addrLat = 0; dataLat = 0;
      tick(3);
      resetn = 1'b1;
      total++;
      if (bus.ireq.valid !== 1'b0 || outValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_state: ivalid=%b out_valid=%b want 0 0", bus.ireq.valid, outValid);
      end
      tick();
      total++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL first_req: valid=%b addr=%h want 1 %h", bus.ireq.valid, bus.ireq.addr, RESET_PC);
      end
      tick();
      total++;
      if (outValid !== 1'b1 || outPc !== RESET_PC || outInstr !== 32'h2408_0001) begin
         bad++;
         $display("[TB] FAIL first_out: v=%b pc=%h instr=%h want 1 %h 24080001", outValid, outPc, outInstr, RESET_PC);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (outValid !== 1'b1 || outPc !== RESET_PC + 32'(4 * i)) begin
            bad++;
            $display("[TB] FAIL stream_rate: v=%b pc=%h want 1 %h", outValid, outPc, RESET_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      outReady = 1'b0;
      tick(5);
      total++;
      if (bus.ireq.valid !== 1'b0 || outValid !== 1'b1 || outPc !== RESET_PC + 32'd16) begin
         bad++;
         $display("[TB] FAIL stall_full: ivalid=%b v=%b pc=%h want 0 1 %h", bus.ireq.valid, outValid, outPc, RESET_PC + 32'd16);
      end
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (outValid !== 1'b1 || outPc !== RESET_PC + 32'(16 + 4 * i)) begin
            bad++;
            $display("[TB] FAIL stall_release: v=%b pc=%h want 1 %h", outValid, outPc, RESET_PC + 32'(16 + 4 * i));
         end
         tick();
      end
   endtask

   task automatic test_slow_bus();
      logic [31:0] a;
      int start, n, k;
      addrLat = 3; dataLat = 2;
      start = reqStarts;
      for (k = 0; k < 20 && reqStarts == start; k++) tick();
      total++;
      if (reqStarts == start) begin
         bad++;
         $display("[TB] FAIL slow_start: no new request within %0d cycles", k);
      end
      a = bus.ireq.addr;
      n = 0;
      for (int j = 0; j < 20 && bus.ireq.valid === 1'b1 && bus.ireq.addr === a; j++) begin
         n++;
         tick();
      end
      total++;
      if (n !== 4) begin
         bad++;
         $display("[TB] FAIL slow_addr_hold: held=%0d want 4", n);
      end
      for (int j = 0; j < 2; j++) begin
         total++;
         if (outValid !== 1'b0 || bus.ireq.valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL slow_wait: v=%b ivalid=%b want 0 0", outValid, bus.ireq.valid);
         end
         tick();
      end
      total++;
      if (outValid !== 1'b1 || outPc !== a) begin
         bad++;
         $display("[TB] FAIL slow_push: v=%b pc=%h want 1 %h", outValid, outPc, a);
      end
      tick();
      total++;
      if (outValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL slow_single_push: v=%b want 0", outValid);
      end
   endtask

   task automatic test_redirect_wait();
      int k;
      addrLat = 0; dataLat = 3;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (k = 0; k < 60 && !(outst && outAddr === 32'hbfc0_0008 && bus.iresp.data_ok === 1'b0); k++) tick();
      total++;
      if (!(outst && outAddr === 32'hbfc0_0008)) begin
         bad++;
         $display("[TB] FAIL redir_setup: never waiting on bfc00008 after %0d cycles", k);
      end
      redirValid = 1'b1; redirPc = 32'hbfc0_0103;
      tick();
      redirValid = 1'b0;
      for (k = 0; k < 20 && bus.ireq.valid !== 1'b1; k++) tick();
      total++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 32'hbfc0_0100) begin
         bad++;
         $display("[TB] FAIL redir_target: valid=%b addr=%h want 1 bfc00100", bus.ireq.valid, bus.ireq.addr);
      end
      for (k = 0; k < 20 && outValid !== 1'b1; k++) tick();
      total++;
      if (outValid !== 1'b1 || outPc !== 32'hbfc0_0100) begin
         bad++;
         $display("[TB] FAIL redir_resume: v=%b pc=%h want 1 bfc00100", outValid, outPc);
      end
   endtask

   task automatic test_redir_with_data();
      logic [31:0] t;
      int k;
      addrLat = 0; dataLat = 1;
      tick(2);
      outReady = 1'b0;
      for (k = 0; k < 40 && !(outValid === 1'b1 && bus.iresp.data_ok === 1'b1); k++) tick();
      total++;
      if (!(outValid === 1'b1 && bus.iresp.data_ok === 1'b1)) begin
         bad++;
         $display("[TB] FAIL rd_setup: no head+data_ok cycle within %0d cycles", k);
      end
      t = RESET_PC + (32'($urandom_range(64, 255)) << 2);
      outReady = 1'b1; redirValid = 1'b1; redirPc = t | 32'($urandom_range(0, 3));
      tick();
      redirValid = 1'b0;
      total++;
      if (outValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rd_flush: v=%b want 0", outValid);
      end
      for (k = 0; k < 20 && bus.ireq.valid !== 1'b1; k++) tick();
      total++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== t) begin
         bad++;
         $display("[TB] FAIL rd_target: valid=%b addr=%h want 1 %h", bus.ireq.valid, bus.ireq.addr, t);
      end
      for (k = 0; k < 20 && outValid !== 1'b1; k++) tick();
      total++;
      if (outValid !== 1'b1 || outPc !== t) begin
         bad++;
         $display("[TB] FAIL rd_resume: v=%b pc=%h want 1 %h", outValid, outPc, t);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      addrLat = 3; dataLat = 0;
      for (k = 0; k < 20 && bus.ireq.valid !== 1'b1; k++) tick();
      resetn = 1'b0;
      tick();
      total++;
      if (bus.ireq.valid !== 1'b0 || outValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_clear: ivalid=%b v=%b want 0 0", bus.ireq.valid, outValid);
      end
      resetn = 1'b1;
      tick();
      total++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL midreset_pc: valid=%b addr=%h want 1 %h", bus.ireq.valid, bus.ireq.addr, RESET_PC);
      end
      for (k = 0; k < 20 && outValid !== 1'b1; k++) tick();
      total++;
      if (outValid !== 1'b1 || outPc !== RESET_PC) begin
         bad++;
         $display("[TB] FAIL midreset_nokill: v=%b pc=%h want 1 %h", outValid, outPc, RESET_PC);
      end
   endtask

   task automatic test_random();
      int startAcc;
      startAcc = accepted;
      randLat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         outReady   = ($urandom_range(0, 3) != 0);
         redirValid = ($urandom_range(0, 39) == 0);
         redirPc    = RESET_PC + 32'($urandom_range(0, 8191));
         tick();
      end
      redirValid = 1'b0; outReady = 1'b1; randLat = 1'b0;
      tick(20);
      total++;
      if (accepted - startAcc < 100) begin
         bad++;
         $display("[TB] FAIL random_progress: accepted=%0d want >=100", accepted - startAcc);
      end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_slow_bus();
      test_redirect_wait();
      test_redir_with_data();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the MIPS core: holds the PC, issues one-word reads on the instruction bus (ibus) and delivers (pc, instr) pairs to the decode stage through a 2-entry buffer with valid/ready flow control. It sits between the ibus port of the core top and the decode stage. Decode or execute redirects it for taken branches and jumps. Wrong-path fetches already in flight are discarded.

## Interface
- RESET_PC, 32'hbfc0_0000, first fetch address after reset
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- ireq  out  ibus_req_t  fields: valid, addr[31:0]
- iresp  in  ibus_resp_t  fields: addr_ok, data_ok, data[31:0]
- redir_valid  in  1  redirect request (single-cycle pulse)
- redir_pc  in  32  redirect target
- out_valid  out  1  an instruction is presented to decode
- out_pc  out  32  PC of the presented instruction
- out_instr  out  32  presented instruction word
- out_ready  in  1  decode accepts the presented instruction this cycle

## Operation
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the current bus request.
  - kill: the in-flight response is wrong-path.
  - state: IDLE, REQ or WAIT.
- Outputs: ireq.valid = (state==REQ); ireq.addr = req_addr.
- Bus rules:
  - Once ireq.valid is asserted, valid and addr stay stable until addr_ok.
  - At most one request is outstanding.
  - data_ok cannot be back-pressured.
- can_issue: 2-entry FIFO occupancy after this cycle's push/pop is ≤1. This guarantees a slot for the next response.
- IDLE:
  - If can_issue: go to REQ and latch req_addr <= pc.
  - Otherwise stay in IDLE.
- REQ:
  - addr_ok & data_ok: complete the response (see below). Then go to REQ with req_addr <= pc+4 if can_issue, else IDLE.
  - addr_ok only: go to WAIT.
  - Neither: stay in REQ.
- WAIT:
  - data_ok: complete the response. Then go to REQ (req_addr <= pc+4) if can_issue, else IDLE.
  - Otherwise stay in WAIT.
- Complete, not killed: push {req_addr, data} into the FIFO; pc <= req_addr+4.
- Complete, killed: drop the data; clear kill; pc unchanged.
- Redirect (redir_valid=1):
  - Flush the FIFO; out_valid is 0 the next cycle.
  - pc <= {redir_pc[31:2], 2'b00}.
  - If state is REQ or WAIT, set kill. The bus transaction still finishes with its original req_addr.
  - A non-killed data_ok in the same cycle is discarded, not pushed.
  - A concurrent out_ready handshake counts as not taken.
  - If state is IDLE, the next request uses the new pc.
- Back-to-back redirects: the last target wins; kill stays set until the response arrives.
- FIFO:
  - Head drives out_pc/out_instr.
  - out_valid = not empty.
  - Pop on out_valid & out_ready & ~redir_valid.
  - Push and pop in the same cycle at count 2 never occurs, because can_issue prevents it.
- Low address bits: req_addr[1:0] is always 00.

## Timing
- Reset (resetn=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, kill=0, FIFO empty.
  - ireq.valid=0, out_valid=0.
  - Reset mid-transaction abandons it; the bus side is reset by the same signal.
- After reset release: cycle 0 IDLE, cycle 1 REQ with addr=RESET_PC.
- With zero-wait memory (addr_ok&data_ok in the same cycle), out_valid is first 1 in cycle 2.
- Steady state with zero-wait memory and out_ready=1: one instruction per cycle.
- Redirect latency: redirect in cycle t (state IDLE) gives a request for the target in cycle t+2. The intervening cycle is IDLE with the new pc.
- A killed in-flight response delays the target request until that response's data_ok.
- out_* are registered FIFO outputs; out_ready has no combinational path to ireq.

## Structure
- Shared package (via common.svh):
  - ibus_req_t and ibus_resp_t (existing).
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - fetch_out_t {pc, instr}.
  - RESET_PC default constant.
- Sub-module fetch_fifo:
  - 2-entry, width 64.
  - Ports: push, pop, flush, count[1:0], head.
  - flush has priority over push.

## Test plan
- Reset then release; memory gives addr_ok&data_ok immediately, data = 32'h2408_0001 → cycle 1 ireq.addr=bfc00000; cycle 2 out_valid=1, out_pc=bfc00000, out_instr=24080001. One word per cycle thereafter at pcs bfc00004, bfc00008, ...
- out_ready=0 for 5 cycles with zero-wait memory → FIFO fills to 2, ireq.valid=0; no data_ok is lost. On release, pcs come out in order with no gaps or duplicates.
- addr_ok delayed 3 cycles, then data_ok 2 cycles later → ireq.addr is stable throughout; exactly one push.
- redir_valid with redir_pc=bfc00103 while in WAIT for bfc00008 → data for bfc00008 is dropped; the next request is bfc00100; out_pc sequence resumes at bfc00100. No bfc00008 or bfc0000c reaches decode.
- redir_valid in the same cycle as a non-killed data_ok and out_ready=1 → FIFO is empty next cycle; the head is not counted as consumed; pc=target.
- resetn=0 while a request is in REQ → next cycle ireq.valid=0, out_valid=0, pc=RESET_PC, kill=0.
